// File: rtl/decode_pipeline.sv
// ID/EX decode stage: decodes a small MIPS subset into a registered EX payload and
// raises a one-cycle stall on a load-use hazard against the instruction already in EX.
module decode_pipeline (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        if_valid,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        stall,
  output logic        ex_valid,
  output logic [1:0]  ex_aluOP,
  output logic [5:0]  ex_sel,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [4:0]  ex_dst,
  output logic        ex_regWrite,
  output logic        ex_memRead,
  output logic        ex_memWrite,
  output logic        illegal,
  output logic [15:0] stall_count
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm;

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign imm    = {{16{instr[15]}}, instr[15:0]};

  logic        dec_legal, dec_reads_rt;
  logic [1:0]  dec_aluop;
  logic [31:0] dec_a, dec_b;
  logic [4:0]  dec_dst;
  logic        dec_regwrite, dec_memread, dec_memwrite;

  always_comb begin
    dec_legal    = 1'b1;
    dec_reads_rt = 1'b0;
    dec_aluop    = 2'b00;
    dec_a        = rs_data;
    dec_b        = imm;
    dec_dst      = 5'd0;
    dec_regwrite = 1'b0;
    dec_memread  = 1'b0;
    dec_memwrite = 1'b0;
    unique case (opcode)
      OpRtype: begin
        dec_reads_rt = 1'b1;
        dec_aluop    = 2'b10;
        dec_b        = rt_data;
        dec_dst      = rd;
        dec_regwrite = 1'b1;
      end
      OpLw: begin
        dec_dst      = rt;
        dec_memread  = 1'b1;
        dec_regwrite = 1'b1;
      end
      OpSw: begin
        dec_reads_rt = 1'b1;
        dec_memwrite = 1'b1;
      end
      OpBeq: begin
        dec_reads_rt = 1'b1;
        dec_aluop    = 2'b01;
        dec_b        = rt_data;
      end
      OpAddi: begin
        dec_aluop    = 2'b11;
        dec_dst      = rt;
        dec_regwrite = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  logic        ex_valid_q, ex_regwrite_q, ex_memread_q, ex_memwrite_q, illegal_q;
  logic [1:0]  ex_aluop_q;
  logic [5:0]  ex_sel_q;
  logic [31:0] ex_a_q, ex_b_q;
  logic [4:0]  ex_dst_q;
  logic [15:0] stall_count_q;

  logic hazard, live, issue;

  // A load into $0 never produces a value worth waiting for.
  assign hazard = ex_valid_q && ex_memread_q && (ex_dst_q != 5'd0) &&
                  ((ex_dst_q == rs) || (dec_reads_rt && (ex_dst_q == rt)));
  assign live   = if_valid && !flush;
  assign stall  = !reset && live && hazard;
  assign issue  = live && !stall && dec_legal;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q    <= 1'b0;
      ex_aluop_q    <= 2'b00;
      ex_sel_q      <= 6'd0;
      ex_a_q        <= 32'd0;
      ex_b_q        <= 32'd0;
      ex_dst_q      <= 5'd0;
      ex_regwrite_q <= 1'b0;
      ex_memread_q  <= 1'b0;
      ex_memwrite_q <= 1'b0;
      illegal_q     <= 1'b0;
      stall_count_q <= 16'd0;
    end else begin
      ex_valid_q    <= issue;
      ex_aluop_q    <= dec_aluop;
      ex_sel_q      <= instr[5:0];
      ex_a_q        <= dec_a;
      ex_b_q        <= dec_b;
      ex_dst_q      <= dec_dst;
      ex_regwrite_q <= issue && dec_regwrite;
      ex_memread_q  <= issue && dec_memread;
      ex_memwrite_q <= issue && dec_memwrite;
      // A stalled instruction is re-presented, so it is flagged on its retry only.
      illegal_q     <= live && !stall && !dec_legal;
      if (stall && (stall_count_q != 16'hFFFF)) begin
        stall_count_q <= stall_count_q + 16'd1;
      end
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_aluOP    = ex_aluop_q;
  assign ex_sel      = ex_sel_q;
  assign ex_a        = ex_a_q;
  assign ex_b        = ex_b_q;
  assign ex_dst      = ex_dst_q;
  assign ex_regWrite = ex_regwrite_q;
  assign ex_memRead  = ex_memread_q;
  assign ex_memWrite = ex_memwrite_q;
  assign illegal     = illegal_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_decode_pipeline.sv
// Scoreboarded bench for decode_pipeline: expected EX payloads are queued when each
// instruction is driven and compared after the following rising edge.
module tb_decode_pipeline;

  logic        clk = 1'b0;
  logic        reset, if_valid, flush;
  logic [31:0] instr, rs_data, rt_data;
  logic        stall, ex_valid, ex_regWrite, ex_memRead, ex_memWrite, illegal;
  logic [1:0]  ex_aluOP;
  logic [5:0]  ex_sel;
  logic [31:0] ex_a, ex_b;
  logic [4:0]  ex_dst;
  logic [15:0] stall_count;

  decode_pipeline dut (
    .clk(clk), .reset(reset), .instr(instr), .if_valid(if_valid), .rs_data(rs_data),
    .rt_data(rt_data), .flush(flush), .stall(stall), .ex_valid(ex_valid),
    .ex_aluOP(ex_aluOP), .ex_sel(ex_sel), .ex_a(ex_a), .ex_b(ex_b), .ex_dst(ex_dst),
    .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
    .illegal(illegal), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [1:0]  op;
    logic [5:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dst;
    logic        rw, mr, mw, ill;
    logic [15:0] cnt;
  } pkt_t;

  typedef struct packed {
    logic        rst;
    logic [31:0] ins;
    logic        ifv;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        fl;
    logic        st;   // expected combinational stall for this cycle
  } stim_t;

  pkt_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_count = 16'd0;

  // Bubbles carry don't-care data; sel only matters for funct-decoded ops.
  function automatic pkt_t norm(input pkt_t p);
    pkt_t r = p;
    if (!r.v) begin
      r.op = '0; r.sel = '0; r.a = '0; r.b = '0; r.dst = '0;
    end
    if (r.op != 2'b10) r.sel = '0;
    return r;
  endfunction

  function automatic pkt_t model(input stim_t s);
    pkt_t        p = '0;
    logic [31:0] sx = {{16{s.ins[15]}}, s.ins[15:0]};
    if (!s.rst && s.ifv && !s.fl && !s.st) begin
      case (s.ins[31:26])
        6'b000000: begin p.v = 1; p.op = 2'b10; p.sel = s.ins[5:0]; p.a = s.rs; p.b = s.rt;
                         p.dst = s.ins[15:11]; p.rw = 1; end
        6'b100011: begin p.v = 1; p.op = 2'b00; p.a = s.rs; p.b = sx; p.dst = s.ins[20:16];
                         p.mr = 1; p.rw = 1; end
        6'b101011: begin p.v = 1; p.op = 2'b00; p.a = s.rs; p.b = sx; p.mw = 1; end
        6'b000100: begin p.v = 1; p.op = 2'b01; p.a = s.rs; p.b = s.rt; end
        6'b001000: begin p.v = 1; p.op = 2'b11; p.a = s.rs; p.b = sx; p.dst = s.ins[20:16];
                         p.rw = 1; end
        default:   p.ill = 1;
      endcase
    end
    return p;
  endfunction

  task automatic drive(input stim_t s);
    pkt_t p;
    @(negedge clk);
    reset = s.rst; instr = s.ins; if_valid = s.ifv; rs_data = s.rs; rt_data = s.rt;
    flush = s.fl;
    if (s.rst) exp_count = 16'd0;
    else if (s.st && exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
    p = model(s);
    p.cnt = exp_count;
    sb.push_back(norm(p));
    #1;
  endtask

  task automatic capture(output pkt_t obs, output pkt_t exp);
    @(posedge clk);
    #1;
    obs = norm('{ex_valid, ex_aluOP, ex_sel, ex_a, ex_b, ex_dst, ex_regWrite, ex_memRead,
                 ex_memWrite, illegal, stall_count});
    exp = sb.pop_front();
  endtask

  function automatic stim_t mk(input logic rst, input logic [31:0] ins, input logic ifv,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic fl, input logic st);
    return '{rst, ins, ifv, rs, rt, fl, st};
  endfunction

  task automatic test_reset();
    stim_t q[$];
    pkt_t  o, e;
    q.push_back(mk(1, 32'h8D28FFFC, 1, 32'd3, 32'd4, 0, 0));
    q.push_back(mk(1, 32'h012A4020, 1, 32'd5, 32'd7, 1, 0));
    foreach (q[i]) begin
      drive(q[i]);
      n_cmp++;
      if (stall !== q[i].st) begin
        n_bad++; $display("FAIL reset_stall[%0d]: got %b want %b", i, stall, q[i].st);
      end
      capture(o, e);
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL reset_ex[%0d]: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_rtype();
    stim_t q[$];
    pkt_t  o, e;
    q.push_back(mk(0, 32'h012A4020, 1, 32'd5, 32'd7, 0, 0));
    q.push_back(mk(0, 32'h012A4022, 1, 32'hFFFF0000, 32'h1234, 0, 0));
    foreach (q[i]) begin
      drive(q[i]);
      n_cmp++;
      if (stall !== q[i].st) begin
        n_bad++; $display("FAIL rtype_stall[%0d]: got %b want %b", i, stall, q[i].st);
      end
      capture(o, e);
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL rtype_ex[%0d]: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_memory_branch();
    stim_t q[$];
    pkt_t  o, e;
    q.push_back(mk(0, 32'h8D28FFFC, 1, 32'd100, 32'd1, 0, 0)); // lw $8,-4($9)
    q.push_back(mk(0, 32'hAD280008, 0, 32'd0, 32'd0, 0, 0));   // bubble
    q.push_back(mk(0, 32'hAD280008, 1, 32'd200, 32'd9, 0, 0)); // sw $8,8($9)
    q.push_back(mk(0, 32'h10220003, 1, 32'd11, 32'd12, 0, 0)); // beq $1,$2
    q.push_back(mk(0, 32'h2023FFFF, 1, 32'd50, 32'd0, 0, 0));  // addi $3,$1,-1
    foreach (q[i]) begin
      drive(q[i]);
      n_cmp++;
      if (stall !== q[i].st) begin
        n_bad++; $display("FAIL mem_stall[%0d]: got %b want %b", i, stall, q[i].st);
      end
      capture(o, e);
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL mem_ex[%0d]: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_load_use();
    stim_t q[$];
    pkt_t  o, e;
    q.push_back(mk(0, 32'h8D28FFFC, 1, 32'd64, 32'd0, 0, 0)); // lw $8
    q.push_back(mk(0, 32'h01095820, 1, 32'd1, 32'd2, 0, 1));  // add $11,$8,$9 (rs hazard)
    q.push_back(mk(0, 32'h01095820, 1, 32'd1, 32'd2, 0, 0));  // re-presented, issues
    q.push_back(mk(0, 32'h8D28FFFC, 1, 32'd64, 32'd0, 0, 0)); // lw $8
    q.push_back(mk(0, 32'h01285820, 1, 32'd3, 32'd4, 0, 1));  // add $11,$9,$8 (rt hazard)
    q.push_back(mk(0, 32'h01285820, 1, 32'd3, 32'd4, 0, 0));
    q.push_back(mk(0, 32'h8D28FFFC, 1, 32'd64, 32'd0, 0, 0)); // lw $8
    q.push_back(mk(0, 32'h20280005, 1, 32'd9, 32'd8, 0, 0));  // addi $8,$1,5: rt not read
    q.push_back(mk(0, 32'h8D200000, 1, 32'd9, 32'd0, 0, 0));  // lw $0
    q.push_back(mk(0, 32'h00005820, 1, 32'd0, 32'd0, 0, 0));  // add $11,$0,$0: no stall
    foreach (q[i]) begin
      drive(q[i]);
      n_cmp++;
      if (stall !== q[i].st) begin
        n_bad++; $display("FAIL loaduse_stall[%0d]: got %b want %b", i, stall, q[i].st);
      end
      capture(o, e);
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL loaduse_ex[%0d]: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_flush();
    stim_t q[$];
    pkt_t  o, e;
    q.push_back(mk(0, 32'h8D28FFFC, 1, 32'd64, 32'd0, 0, 0)); // lw $8
    q.push_back(mk(0, 32'h01095820, 1, 32'd1, 32'd2, 1, 0));  // dependent add, flushed
    q.push_back(mk(0, 32'hFC000000, 1, 32'd1, 32'd2, 1, 0));  // flushed illegal: no pulse
    q.push_back(mk(0, 32'h012A4020, 1, 32'd5, 32'd7, 0, 0));
    foreach (q[i]) begin
      drive(q[i]);
      n_cmp++;
      if (stall !== q[i].st) begin
        n_bad++; $display("FAIL flush_stall[%0d]: got %b want %b", i, stall, q[i].st);
      end
      capture(o, e);
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL flush_ex[%0d]: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_illegal();
    stim_t q[$];
    pkt_t  o, e;
    q.push_back(mk(0, 32'hFC000000, 1, 32'd1, 32'd2, 0, 0)); // opcode 0x3F
    q.push_back(mk(0, 32'h00000000, 0, 32'd0, 32'd0, 0, 0)); // pulse must drop
    q.push_back(mk(0, 32'hFC000000, 0, 32'd1, 32'd2, 0, 0)); // not valid: no pulse
    foreach (q[i]) begin
      drive(q[i]);
      n_cmp++;
      if (stall !== q[i].st) begin
        n_bad++; $display("FAIL illegal_stall[%0d]: got %b want %b", i, stall, q[i].st);
      end
      capture(o, e);
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL illegal_ex[%0d]: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_reset_mid_stall();
    stim_t q[$];
    pkt_t  o, e;
    q.push_back(mk(0, 32'h8D28FFFC, 1, 32'd64, 32'd0, 0, 0)); // lw $8
    q.push_back(mk(1, 32'h01095820, 1, 32'd1, 32'd2, 0, 0));  // hazard present, reset wins
    q.push_back(mk(0, 32'h01095820, 1, 32'd1, 32'd2, 0, 0));  // decodes without stall
    foreach (q[i]) begin
      drive(q[i]);
      n_cmp++;
      if (stall !== q[i].st) begin
        n_bad++; $display("FAIL rststall_stall[%0d]: got %b want %b", i, stall, q[i].st);
      end
      capture(o, e);
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL rststall_ex[%0d]: got %h want %h", i, o, e); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; instr = '0; if_valid = 1'b0; rs_data = '0; rt_data = '0; flush = 1'b0;
    test_reset();
    test_rtype();
    test_memory_branch();
    test_load_use();
    test_flush();
    test_illegal();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_pipeline.md
DECODE_PIPELINE -- requirements
Module: decode_pipeline

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 clk  in  1  rising-edge clock for every register.
REQ-003 reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
REQ-004 instr  in  32  instruction presented by the IF/ID stage.
REQ-005 if_valid  in  1  instr is a real instruction (0 = bubble).
REQ-006 rs_data  in  32  register-file read of instr[25:21].
REQ-007 rt_data  in  32  register-file read of instr[20:16].
REQ-008 flush  in  1  kill the instruction currently in ID (branch resolved taken).
REQ-009 stall  out  1  combinational; 1 = upstream SHALL hold instr/PC this cycle.
REQ-010 ex_valid  out  1  registered; the EX-stage payload is live.
REQ-011 ex_aluOP  out  2  registered ALU operation class: 00 add, 01 sub/compare, 10 funct-decoded, 11 add-immediate.
REQ-012 ex_sel  out  6  registered funct field, instr[5:0]; meaningful only when ex_aluOP=10.
REQ-013 ex_a, ex_b  out  32 each  registered ALU operands.
REQ-014 ex_dst  out  5  registered destination register.
REQ-015 ex_regWrite, ex_memRead, ex_memWrite  out  1 each  registered control bits.
REQ-016 illegal  out  1  registered one-cycle pulse flagging an unsupported opcode.
REQ-017 stall_count  out  16  registered count of stall cycles; saturates.

Function
REQ-018 Decode SHALL be by opcode = instr[31:26], with rs = instr[25:21], rt = instr[20:16], rd = instr[15:11], and imm = sign-extended instr[15:0] (32 bits).
REQ-019 Opcode 000000 (R-type): aluOP=10, sel=funct, a=rs_data, b=rt_data, dst=rd, regWrite=1.
REQ-020 Opcode 100011 (lw): aluOP=00, a=rs_data, b=imm, dst=rt, memRead=1, regWrite=1.
REQ-021 Opcode 101011 (sw): aluOP=00, a=rs_data, b=imm, memWrite=1, regWrite=0, dst=0.
REQ-022 Opcode 000100 (beq): aluOP=01, a=rs_data, b=rt_data, regWrite=0, dst=0.
REQ-023 Opcode 001000 (addi): aluOP=11, a=rs_data, b=imm, dst=rt, regWrite=1.
REQ-024 Any other opcode with if_valid=1 and no flush SHALL load a bubble and pulse illegal=1 for exactly one cycle.
REQ-025 Bubble SHALL mean ex_valid=0 with regWrite=memRead=memWrite=0; the data fields (aluOP, sel, a, b, dst) are don't-care.
REQ-026 Latency SHALL be one cycle: the decode of instr is visible on ex_* on the next rising edge.
REQ-027 Load-use hazard: stall SHALL be 1 when all of the following hold:
  - if_valid=1 and flush=0;
  - ex_valid=1 and ex_memRead=1 and ex_dst!=0;
  - ex_dst==rs, or ex_dst==rt for an instruction that reads rt (R-type, sw, beq).
REQ-028 While stall=1, the next EX load SHALL be a bubble; instr is re-presented by upstream and decoded on the following cycle.
REQ-029 A stall SHALL last at most one cycle, because the bubble clears ex_memRead.
REQ-030 Flush SHALL take priority over stall and illegal: stall=0, a bubble is loaded, and illegal is not pulsed.
REQ-031 if_valid=0 SHALL load a bubble with stall=0 and illegal=0.
REQ-032 stall_count SHALL increment by 1 on each clock edge where stall=1, and hold at 16'hFFFF.
REQ-033 Register 0 as a destination SHALL never cause a stall.

Reset
REQ-034 With reset=1 at a clock edge, the block SHALL set ex_valid=0, all ex_* control bits and fields=0, illegal=0, and stall_count=0.
REQ-035 Reset SHALL override flush, stall and decode; stall SHALL be 0 while reset=1.
REQ-036 After a reset during a pending stall, the first post-reset instruction SHALL decode without a stall.

Verification
REQ-037 R-type add: instr=0x012A4020 (add $8,$9,$10), rs_data=5, rt_data=7 -> next cycle: ex_aluOP=10, ex_sel=100000, ex_a=5, ex_b=7, ex_dst=8, ex_regWrite=1.
REQ-038 lw with negative offset: instr=0x8D28FFFC (lw $8,-4($9)) -> ex_aluOP=00, ex_b=0xFFFFFFFC, ex_dst=8, ex_memRead=1.
REQ-039 Load-use: lw $8 followed by add $11,$8,$9 -> stall=1 for one cycle, one bubble in EX, then the add issues; stall_count=1.
REQ-040 Flush over hazard: lw $8 then dependent add with flush=1 -> stall=0, bubble loaded, illegal=0, stall_count unchanged.
REQ-041 Illegal opcode 0x3F with if_valid=1 -> ex_valid=0, illegal=1 for exactly one cycle.
REQ-042 Reset mid-stall: assert reset while stall=1 -> next cycle all outputs are 0 and stall_count=0.
